expression_control: RTL and testbench

- Control unit that sequences the operative datapath through one expression evaluation per start request.
- Drives the datapath's register loads (LX, LS, LH), ALU op select (H) and mux selects (M0, M1, M2).
- Consumes the datapath's overflow and zero flags.
- Sits directly upstream of the operative block and provides a start/done handshake to the system.

---
 rtl/expression_control_pkg.sv | 56 +++++
 rtl/expression_control.sv | 126 ++++++++++++
 tb/tb_expression_control.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/expression_control_pkg.sv
// Shared encodings for the expression control unit: FSM states, ALU op values
// and datapath mux selects.
package expression_control_pkg;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOAD_X = 4'd1;
   localparam logic [3:0] S_MUL_AX = 4'd2;
   localparam logic [3:0] S_ADD_B  = 4'd3;
   localparam logic [3:0] S_MUL_X  = 4'd4;
   localparam logic [3:0] S_ADD_C  = 4'd5;
   localparam logic [3:0] S_ADD_HX = 4'd6;
   localparam logic [3:0] S_ADD_SX = 4'd7;
   localparam logic [3:0] S_MUL_SH = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;

   localparam logic H_ADD = 1'b0;
   localparam logic H_MUL = 1'b1;

   // M0: constant/operand source
   localparam logic [1:0] M0_ZERO = 2'd0;
   localparam logic [1:0] M0_A    = 2'd1;
   localparam logic [1:0] M0_B    = 2'd2;
   localparam logic [1:0] M0_C    = 2'd3;

   // M1: ALU operand 1
   localparam logic [1:0] M1_M0 = 2'd0;
   localparam logic [1:0] M1_X  = 2'd1;
   localparam logic [1:0] M1_S  = 2'd2;
   localparam logic [1:0] M1_H  = 2'd3;

   // M2: ALU operand 2
   localparam logic [1:0] M2_X  = 2'd0;
   localparam logic [1:0] M2_M0 = 2'd1;
   localparam logic [1:0] M2_S  = 2'd2;
   localparam logic [1:0] M2_H  = 2'd3;

   typedef struct packed {
      logic       lx;
      logic       ls;
      logic       lh;
      logic       h;
      logic [1:0] m0;
      logic [1:0] m1;
      logic [1:0] m2;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{lx: 1'b0, ls: 1'b0, lh: 1'b0, h: H_ADD,
                                   m0: M0_ZERO, m1: M1_M0, m2: M2_X};

   function automatic logic is_arith(input logic [3:0] st);
      return (st == S_MUL_AX) || (st == S_ADD_B)  || (st == S_MUL_X) ||
             (st == S_ADD_C)  || (st == S_ADD_HX) || (st == S_ADD_SX) ||
             (st == S_MUL_SH);
   endfunction

endpackage

// File: rtl/expression_control.sv
// Moore sequencer driving the operative datapath through one expression
// evaluation per accepted start.
//
// state  | meaning
// IDLE   | waiting for start; mode captured on accept
// LOAD_X | load Reg_X
// MUL_AX | S = A*X              (mode 0)
// ADD_B  | S = S+B              (mode 0)
// MUL_X  | S = X*S              (mode 0)
// ADD_C  | S = C+S              (mode 0)
// ADD_HX | H = A+X              (mode 1)
// ADD_SX | S = B+X              (mode 1)
// MUL_SH | S = H*S              (mode 1)
// DONE   | done pulse, capture zero flag
module expression_control
   import expression_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       overflow,
   input  logic       zero,
   output logic       LX,
   output logic       LS,
   output logic       LH,
   output logic       H,
   output logic [1:0] M0,
   output logic [1:0] M1,
   output logic [1:0] M2,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       res_zero
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       mode_q;
   ctrl_t      ctrl;

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:   state_nxt = start ? S_LOAD_X : S_IDLE;
         S_LOAD_X: state_nxt = mode_q ? S_ADD_HX : S_MUL_AX;
         S_MUL_AX: state_nxt = S_ADD_B;
         S_ADD_B:  state_nxt = S_MUL_X;
         S_MUL_X:  state_nxt = S_ADD_C;
         S_ADD_C:  state_nxt = S_DONE;
         S_ADD_HX: state_nxt = S_ADD_SX;
         S_ADD_SX: state_nxt = S_MUL_SH;
         S_MUL_SH: state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         mode_q   <= 1'b0;
         err      <= 1'b0;
         res_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            mode_q   <= mode;
            err      <= 1'b0;
            res_zero <= 1'b0;
         end
         if (is_arith(state) && overflow) begin
            err <= 1'b1;
         end
         if (state == S_DONE) begin
            res_zero <= zero;
         end
      end
   end

   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         S_LOAD_X: ctrl.lx = 1'b1;
         S_MUL_AX: begin
            ctrl.h  = H_MUL; ctrl.m0 = M0_A; ctrl.m1 = M1_M0; ctrl.m2 = M2_X;
            ctrl.ls = 1'b1;
         end
         S_ADD_B: begin
            ctrl.h  = H_ADD; ctrl.m0 = M0_B; ctrl.m1 = M1_M0; ctrl.m2 = M2_S;
            ctrl.ls = 1'b1;
         end
         S_MUL_X: begin
            ctrl.h  = H_MUL; ctrl.m1 = M1_X; ctrl.m2 = M2_S;
            ctrl.ls = 1'b1;
         end
         S_ADD_C: begin
            ctrl.h  = H_ADD; ctrl.m0 = M0_C; ctrl.m1 = M1_M0; ctrl.m2 = M2_S;
            ctrl.ls = 1'b1;
         end
         S_ADD_HX: begin
            ctrl.h  = H_ADD; ctrl.m0 = M0_A; ctrl.m1 = M1_M0; ctrl.m2 = M2_X;
            ctrl.lh = 1'b1;
         end
         S_ADD_SX: begin
            ctrl.h  = H_ADD; ctrl.m0 = M0_B; ctrl.m1 = M1_M0; ctrl.m2 = M2_X;
            ctrl.ls = 1'b1;
         end
         S_MUL_SH: begin
            ctrl.h  = H_MUL; ctrl.m1 = M1_H; ctrl.m2 = M2_S;
            ctrl.ls = 1'b1;
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

   assign LX   = ctrl.lx;
   assign LS   = ctrl.ls;
   assign LH   = ctrl.lh;
   assign H    = ctrl.h;
   assign M0   = ctrl.m0;
   assign M1   = ctrl.m1;
   assign M2   = ctrl.m2;
   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_expression_control.sv
// Scoreboard bench: a behavioural datapath closes the loop around the
// controller; expected results come from the arithmetic rules directly.
module tb_expression_control;

   logic clk = 1'b0;
   logic rst, start, mode, overflow, zero;
   logic LX, LS, LH, H, busy, done, err, res_zero;
   logic [1:0] M0, M1, M2;

   logic [15:0] in_a, in_b, in_c, in_x;
   logic [15:0] reg_x, reg_s, reg_h;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int free_at = 0;
   logic last_err = 1'b0;
   logic last_rz = 1'b0;

   typedef struct {
      int          issue;
      logic        mode;
      logic [15:0] s;
      logic        err;
      logic        rz;
   } exp_t;
   exp_t q[$];

   expression_control dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .overflow(overflow), .zero(zero),
      .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
      .busy(busy), .done(done), .err(err), .res_zero(res_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural operative block
   logic [15:0] m0_out, op1, op2;
   logic [31:0] alu_full;
   always_comb begin
      m0_out = 16'd0;
      case (M0)
         2'd1: m0_out = in_a;
         2'd2: m0_out = in_b;
         2'd3: m0_out = in_c;
         default: m0_out = 16'd0;
      endcase
      op1 = (M1 == 2'd0) ? m0_out : (M1 == 2'd1) ? reg_x : (M1 == 2'd2) ? reg_s : reg_h;
      op2 = (M2 == 2'd0) ? reg_x : (M2 == 2'd1) ? m0_out : (M2 == 2'd2) ? reg_s : reg_h;
      alu_full = H ? ({16'd0, op1} * {16'd0, op2}) : ({16'd0, op1} + {16'd0, op2});
      overflow = (alu_full > 32'h0000_FFFF);
      zero = (reg_s == 16'd0);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_x <= 16'd0; reg_s <= 16'd0; reg_h <= 16'd0;
      end else begin
         if (LX) reg_x <= in_x;
         if (LS) reg_s <= alu_full[15:0];
         if (LH) reg_h <= alu_full[15:0];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
      end
   endtask

   function automatic void ref_eval(input logic m, input logic [15:0] a, b, c, x,
                                    output logic [15:0] s, output logic e);
      longint t, h;
      e = 1'b0;
      if (!m) begin
         t = longint'(a) * longint'(x);  if (t > 65535) e = 1'b1; t = t & 65535;
         t = t + longint'(b);            if (t > 65535) e = 1'b1; t = t & 65535;
         t = t * longint'(x);            if (t > 65535) e = 1'b1; t = t & 65535;
         t = t + longint'(c);            if (t > 65535) e = 1'b1; t = t & 65535;
      end else begin
         h = longint'(a) + longint'(x);  if (h > 65535) e = 1'b1; h = h & 65535;
         t = longint'(b) + longint'(x);  if (t > 65535) e = 1'b1; t = t & 65535;
         t = t * h;                      if (t > 65535) e = 1'b1; t = t & 65535;
      end
      s = t[15:0];
   endfunction

   function automatic logic [10:0] cw(input logic lx, ls, lh, h, input logic [1:0] m0, m1, m2,
                                      input logic d);
      return {lx, ls, lh, h, m0, m1, m2, d};
   endfunction

   // expected control word by cycle offset from the accepting edge
   function automatic logic [10:0] exp_word(input logic m, input int off);
      if (off == 0) return cw(1, 0, 0, 0, 0, 0, 0, 0);
      if (!m) begin
         case (off)
            1: return cw(0, 1, 0, 1, 1, 0, 0, 0);
            2: return cw(0, 1, 0, 0, 2, 0, 2, 0);
            3: return cw(0, 1, 0, 1, 0, 1, 2, 0);
            4: return cw(0, 1, 0, 0, 3, 0, 2, 0);
            5: return cw(0, 0, 0, 0, 0, 0, 0, 1);
            default: return 11'd0;
         endcase
      end
      case (off)
         1: return cw(0, 0, 1, 0, 1, 0, 0, 0);
         2: return cw(0, 1, 0, 0, 2, 0, 0, 0);
         3: return cw(0, 1, 0, 1, 0, 3, 2, 0);
         4: return cw(0, 0, 0, 0, 0, 0, 0, 1);
         default: return 11'd0;
      endcase
   endfunction

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         logic        eb;
         int          off;
         logic [10:0] act_w;
         act_w = {LX, LS, LH, H, M0, M1, M2, done};
         eb = (q.size() > 0) && (cyc >= q[0].issue);
         chk("busy", {31'd0, busy}, {31'd0, eb});
         if (eb) begin
            off = cyc - q[0].issue;
            chk("ctrl_word", {21'd0, act_w}, {21'd0, exp_word(q[0].mode, off)});
            if (off == (q[0].mode ? 4 : 5)) begin
               chk("result_s", {16'd0, reg_s}, {16'd0, q[0].s});
               chk("err_at_done", {31'd0, err}, {31'd0, q[0].err});
               last_err = q[0].err;
               last_rz  = q[0].rz;
               void'(q.pop_front());
            end
         end else begin
            chk("idle_word", {21'd0, act_w}, 32'd0);
            chk("idle_err", {31'd0, err}, {31'd0, last_err});
            chk("idle_res_zero", {31'd0, res_zero}, {31'd0, last_rz});
         end
      end
   end

   task automatic step(input logic st, input logic md, input logic [15:0] a, b, c, x);
      exp_t e;
      @(negedge clk);
      start = st;
      mode  = md;
      if (st && (cyc + 1 >= free_at)) begin
         in_a = a; in_b = b; in_c = c; in_x = x;
         e.issue = cyc + 1;
         e.mode  = md;
         ref_eval(md, a, b, c, x, e.s, e.err);
         e.rz    = (e.s == 16'd0);
         q.push_back(e);
         free_at = cyc + 1 + (md ? 4 : 5) + 2;
      end
   endtask

   task automatic run(input logic md, input logic [15:0] a, b, c, x);
      step(1'b1, md, a, b, c, x);
      repeat (7) step(1'b0, md, a, b, c, x);
   endtask

   function automatic logic [15:0] rnd16();
      return ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
   endfunction

   initial begin
      rst = 1'b0; start = 1'b0; mode = 1'b0;
      in_a = 16'd0; in_b = 16'd0; in_c = 16'd0; in_x = 16'd0;
      #1;
      chk("reset_word", {21'd0, LX, LS, LH, H, M0, M1, M2, done}, 32'd0);
      chk("reset_flags", {29'd0, busy, err, res_zero}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      run(1'b0, 16'd2, 16'd4, 16'd5, 16'd3);        // 35
      run(1'b1, 16'd2, 16'd4, 16'd0, 16'd1);        // 15
      chk("reg_h_mode1", {16'd0, reg_h}, 32'd3);
      run(1'b0, 16'd1, 16'd0, 16'd0, 16'd0);        // zero result
      run(1'b0, 16'h4000, 16'd0, 16'd0, 16'd8);     // overflow in MUL_AX
      repeat (3) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      run(1'b0, 16'd2, 16'd4, 16'd5, 16'd3);        // clean run clears err

      // start held high, mode toggling every cycle
      for (int i = 0; i < 24; i++)
         step(1'b1, i[0], rnd16(), rnd16(), rnd16(), rnd16());
      repeat (7) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);

      // asynchronous abort while in MUL_X
      step(1'b1, 1'b0, 16'd7, 16'd1, 16'd1, 16'd2);
      repeat (4) step(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
      #2 rst = 1'b0;
      #1;
      chk("abort_word", {21'd0, LX, LS, LH, H, M0, M1, M2, done}, 32'd0);
      chk("abort_flags", {29'd0, busy, err, res_zero}, 32'd0);
      q.delete();
      free_at = 0; last_err = 1'b0; last_rz = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (3) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      run(1'b0, 16'd2, 16'd4, 16'd5, 16'd3);

      // random traffic, including starts while busy
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
              rnd16(), rnd16(), rnd16(), rnd16());
      repeat (8) step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
